// File: rtl/cu_step_controller_if.sv
// cu_step_controller_if: link between the run/step controller and the control address register.
interface cu_step_controller_if;
  logic [1:0] i_control_word_car;
  logic       i_ctrl_halt;
  logic       ctrl_cpu_start;
  logic       ctrl_step_execution;
  logic       o_next_instr_stimulus;
  modport master (
    input  i_control_word_car, i_ctrl_halt,
    output ctrl_cpu_start, ctrl_step_execution, o_next_instr_stimulus
  );
  modport slave (
    output i_control_word_car, i_ctrl_halt,
    input  ctrl_cpu_start, ctrl_step_execution, o_next_instr_stimulus
  );
endinterface

// File: rtl/cu_step_controller.sv
// cu_step_controller: run/step front end for the CAR; debounces buttons, detects
// instruction boundaries, releases one instruction per step press and counts instructions.
module cu_step_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int INSTR_CNT_W     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_btn_start,
  input  logic                   i_btn_step,
  input  logic                   i_sw_step_mode,
  cu_step_controller_if.master   car,
  output logic                   o_waiting,
  output logic                   o_halted,
  output logic [INSTR_CNT_W-1:0] o_instr_count
);
  // PULSE behaves like RUN but carries the one-cycle release to the CAR
  typedef enum logic [2:0] {IDLE, RUN, WAIT, PULSE, HALTED} state_t;
  state_t state, state_n;
  logic [2:0] sync1, sync2;
  logic [1:0][CNT_W-1:0] db_cnt;
  logic [1:0] db_lvl, press;
  logic step_mode, armed, boundary;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      step_mode <= 1'b0;
    end else begin
      sync1 <= {i_sw_step_mode, i_btn_step, i_btn_start};
      sync2 <= sync1;
      step_mode <= sync2[2];
    end
  // index 0 = start button, 1 = step button; press fires only on an accepted rise
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      db_cnt <= '0;
      db_lvl <= '0;
      press <= '0;
    end else
      for (int k = 0; k < 2; k++) begin
        press[k] <= 1'b0;
        if (sync2[k] == db_lvl[k])
          db_cnt[k] <= '0;
        else if (db_cnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[k] <= '0;
          db_lvl[k] <= sync2[k];
          press[k] <= sync2[k];
        end else
          db_cnt[k] <= db_cnt[k] + 1'b1;
      end
  assign boundary = car.ctrl_cpu_start & armed & (car.i_control_word_car == 2'b11);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      armed <= 1'b1;
      o_instr_count <= '0;
    end else begin
      armed <= (car.i_control_word_car != 2'b11) | (armed & ~boundary);
      if (boundary & ~car.i_ctrl_halt) o_instr_count <= o_instr_count + 1'b1;
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = press[0] ? RUN : IDLE;
      RUN, PULSE: state_n = boundary & car.i_ctrl_halt ? HALTED :
                            boundary & step_mode       ? WAIT   : RUN;
      WAIT:       state_n = !step_mode ? RUN : press[1] ? PULSE : WAIT;
      HALTED:     state_n = HALTED;
      default:    state_n = IDLE;
    endcase
  end
  always_comb begin
    car.ctrl_cpu_start        = state != IDLE;
    car.o_next_instr_stimulus = state == PULSE;
    car.ctrl_step_execution   = step_mode;
    o_waiting                 = state == WAIT;
    o_halted                  = state == HALTED;
  end
endmodule
